// File: rtl/cpu_pkg.sv
// cpu_pkg: shared fetch constants and entry type (misalign field under IFETCH_MISALIGN_CHECK_EN)
package cpu_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [XLEN-1:0] PC_INC = 32'd4;
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
`ifdef IFETCH_MISALIGN_CHECK_EN
    logic misalign;
`endif
  } fetch_entry_t;
endpackage

// File: rtl/ifetch_unit_if.sv
// ifetch_if: imem, redirect and decode signals of the fetch stage (out_misalign under IFETCH_MISALIGN_CHECK_EN)
interface ifetch_if;
  import cpu_pkg::*;
  logic [XLEN-1:0] iaddr;
  logic [XLEN-1:0] idata;
  logic redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic out_valid;
  logic out_ready;
  logic [XLEN-1:0] out_instr;
  logic [XLEN-1:0] out_pc;
`ifdef IFETCH_MISALIGN_CHECK_EN
  logic out_misalign;
  modport master (output iaddr, out_valid, out_instr, out_pc, out_misalign,
                  input idata, redirect_valid, redirect_pc, out_ready);
  modport slave (input iaddr, out_valid, out_instr, out_pc, out_misalign,
                 output idata, redirect_valid, redirect_pc, out_ready);
`else
  modport master (output iaddr, out_valid, out_instr, out_pc,
                  input idata, redirect_valid, redirect_pc, out_ready);
  modport slave (input iaddr, out_valid, out_instr, out_pc,
                 output idata, redirect_valid, redirect_pc, out_ready);
`endif
endinterface

// File: rtl/ifetch_unit_buffer.sv
// ifetch_buffer: 2-entry fetch FIFO with flush; head holds last shown entry while empty
module ifetch_buffer
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         enq,
  input  logic         deq,
  input  fetch_entry_t enq_entry,
  output fetch_entry_t head,
  output logic         valid,
  output logic         full
);
  fetch_entry_t mem_q [2];
  fetch_entry_t mem_d [2];
  fetch_entry_t last_q, last_d, rst_entry;
  logic rd_q, rd_d, wr_q, wr_d;
  logic [1:0] cnt_q, cnt_d;
  // pointer/count update, tail write and head selection
  always_comb begin
    rst_entry = '0;
    rst_entry.pc = RESET_PC;
    rst_entry.instr = INSTR_NOP;
    mem_d = mem_q;
    if (enq) mem_d[wr_q] = enq_entry;
    rd_d = flush ? 1'b0 : rd_q ^ deq;
    wr_d = flush ? 1'b0 : wr_q ^ enq;
    cnt_d = flush ? 2'd0 : cnt_q + 2'(enq) - 2'(deq);
    valid = cnt_q != 2'd0;
    full = cnt_q == 2'd2;
    head = valid ? mem_q[rd_q] : last_q;
    last_d = head;
  end
  // storage and control registers
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (reset) begin
      rd_q <= 1'b0;
      wr_q <= 1'b0;
      cnt_q <= 2'd0;
      last_q <= rst_entry;
    end else begin
      rd_q <= rd_d;
      wr_q <= wr_d;
      cnt_q <= cnt_d;
      last_q <= last_d;
    end
  end
endmodule

// File: rtl/ifetch_unit.sv
// ifetch_unit: PC register, next-PC mux and fetch buffer; IFETCH_MISALIGN_CHECK_EN adds misalign tagging and halt
module ifetch_unit
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int BUF_DEPTH = 2
) (
  input logic      clk,
  input logic      reset,
  ifetch_if.master bus
);
  if (BUF_DEPTH != 2) begin : g_bad_depth
    $error("ifetch_unit: BUF_DEPTH must be 2");
  end
  logic [XLEN-1:0] pc_q, pc_d;
  logic enq, deq, full, valid, stall;
  fetch_entry_t enq_entry, head;
`ifdef IFETCH_MISALIGN_CHECK_EN
  logic halt_q, halt_d;
  assign stall = halt_q;
  assign bus.out_misalign = head.misalign;
  // a misaligned fetch halts further fetching until the next redirect
  always_comb halt_d = bus.redirect_valid ? 1'b0 : (halt_q | (enq & enq_entry.misalign));
  // halt flag register
  always_ff @(posedge clk) halt_q <= reset ? 1'b0 : halt_d;
`else
  assign stall = 1'b0;
`endif
  // handshake, enqueue decision and next-PC selection
  always_comb begin
    deq = valid & bus.out_ready;
    enq = ~bus.redirect_valid & ~stall & (~full | deq);
    pc_d = bus.redirect_valid ? bus.redirect_pc : enq ? pc_q + PC_INC : pc_q;
    enq_entry = '0;
    enq_entry.pc = pc_q;
    enq_entry.instr = bus.idata;
`ifdef IFETCH_MISALIGN_CHECK_EN
    enq_entry.misalign = pc_q[1:0] != 2'b00;
`endif
  end
  // program counter
  always_ff @(posedge clk) pc_q <= reset ? RESET_PC : pc_d;
  ifetch_buffer #(.RESET_PC(RESET_PC)) u_buf (
    .clk(clk),
    .reset(reset),
    .flush(bus.redirect_valid),
    .enq(enq),
    .deq(deq),
    .enq_entry(enq_entry),
    .head(head),
    .valid(valid),
    .full(full)
  );
  assign bus.iaddr = pc_q;
  assign bus.out_valid = valid;
  assign bus.out_instr = head.instr;
  assign bus.out_pc = head.pc;
endmodule

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit: directed checks of fetch order, backpressure, redirect, wrap and reset
module tb_ifetch_unit;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int failures = 0;
  ifetch_if bus ();
  ifetch_unit dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a == 32'h0 ? 32'h11 : a == 32'h4 ? 32'h22 : a == 32'h8 ? 32'h33 : a ^ 32'hdead_0000;
  endfunction
  always_comb bus.idata = mem_word(bus.iaddr);
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic head(input string tag, input logic [31:0] pc);
    check({tag, "_v"}, 32'(bus.out_valid), 32'd1);
    check({tag, "_pc"}, bus.out_pc, pc);
    check({tag, "_in"}, bus.out_instr, mem_word(pc));
  endtask
  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask
  initial begin
    bus.out_ready = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 32'h0;
    do_reset();
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_iaddr", bus.iaddr, 32'h0);
    check("rst_instr", bus.out_instr, 32'h13);
    check("rst_pc", bus.out_pc, 32'h0);
    step(); head("s0", 32'h0); check("s0_iaddr", bus.iaddr, 32'h4);
    check("s0_in_lit", bus.out_instr, 32'h11);
    step(); head("s1", 32'h4); check("s1_in_lit", bus.out_instr, 32'h22);
    step(); head("s2", 32'h8); check("s2_in_lit", bus.out_instr, 32'h33);
    do_reset();
    step(); head("bp0", 32'h0);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      head("bp_hold", 32'h0);
      check("bp_iaddr", bus.iaddr, 32'h8);
    end
    bus.out_ready = 1'b1;
    step(); head("dr0", 32'h4);
    step(); head("dr1", 32'h8);
    step(); head("dr2", 32'hC);
    bus.out_ready = 1'b0;
    step(); head("full", 32'hC);
    check("full_iaddr", bus.iaddr, 32'h14);
    bus.out_ready = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h100;
    step();
    bus.redirect_valid = 1'b0;
    check("rd_valid", 32'(bus.out_valid), 32'd0);
    check("rd_iaddr", bus.iaddr, 32'h100);
    check("rd_hold_pc", bus.out_pc, 32'hC);
    step(); head("rd0", 32'h100);
    step(); head("rd1", 32'h104);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'hFFFF_FFFC;
    step();
    bus.redirect_valid = 1'b0;
    check("wr_valid", 32'(bus.out_valid), 32'd0);
    step(); head("wr0", 32'hFFFF_FFFC); check("wr_iaddr", bus.iaddr, 32'h0);
    step(); head("wr1", 32'h0);
    bus.out_ready = 1'b0;
    step(); step();
    do_reset();
    check("mr_valid", 32'(bus.out_valid), 32'd0);
    check("mr_iaddr", bus.iaddr, 32'h0);
    check("mr_pc", bus.out_pc, 32'h0);
    check("mr_instr", bus.out_instr, 32'h13);
    bus.out_ready = 1'b1;
    step(); head("mr0", 32'h0);
    step(); head("mr1", 32'h4);
`ifdef IFETCH_MISALIGN_CHECK_EN
    check("ma_clear", 32'(bus.out_misalign), 32'd0);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h102;
    step();
    bus.redirect_valid = 1'b0;
    step(); head("ma0", 32'h102);
    check("ma_flag", 32'(bus.out_misalign), 32'd1);
    for (int i = 0; i < 4; i++) begin
      step();
      check("ma_halt", 32'(bus.out_valid), 32'd0);
    end
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h200;
    step();
    bus.redirect_valid = 1'b0;
    step(); head("ma1", 32'h200);
    check("ma_flag0", 32'(bus.out_misalign), 32'd0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
